// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and write-back request type for the register file
package regfile_pkg;

  localparam int XLEN         = 32;
  localparam int REG_ID_W     = 6;
  localparam bit HAS_IRQ_REGS = 1'b1;
  localparam int NUM_REGS     = HAS_IRQ_REGS ? 36 : 32;

  typedef struct packed {
    logic                valid;
    logic [REG_ID_W-1:0] id;
    logic [XLEN-1:0]     data;
  } wb_req_t;

  // Register 0 is hardwired, so it never matches anything uncommitted.
  function automatic logic id_match(input logic [REG_ID_W-1:0] a,
                                    input logic [REG_ID_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// rtl/wb_pend_fifo.sv - pending load-return buffer with per-entry valid, id squash and
// youngest-first forwarding lookup
module wb_pend_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              push_i,
  input  logic [regfile_pkg::REG_ID_W-1:0]  push_id_i,
  input  logic [regfile_pkg::XLEN-1:0]      push_data_i,
  input  logic                              pop_i,
  input  logic                              squash_i,
  input  logic [regfile_pkg::REG_ID_W-1:0]  squash_id_i,
  output logic                              head_valid_o,
  output logic [regfile_pkg::REG_ID_W-1:0]  head_id_o,
  output logic [regfile_pkg::XLEN-1:0]      head_data_o,
  input  logic [regfile_pkg::REG_ID_W-1:0]  lk1_id_i,
  input  logic [regfile_pkg::REG_ID_W-1:0]  lk2_id_i,
  output logic                              lk1_hit_o,
  output logic [regfile_pkg::XLEN-1:0]      lk1_data_o,
  output logic                              lk2_hit_o,
  output logic [regfile_pkg::XLEN-1:0]      lk2_data_o,
  output logic [$clog2(DEPTH):0]            cnt_o
);
  import regfile_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_ID_W-1:0] id_q   [DEPTH];
  logic [XLEN-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    idx;

  assign head_valid_o = vld_q[rd_ptr_q];
  assign head_id_o    = id_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];
  assign cnt_o        = cnt_q;

  // Squashed entries keep their slot; only the valid bit drops.
  always_comb begin
    vld_d = vld_q;
    if (squash_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (id_q[i] == squash_id_i) vld_d[i] = 1'b0;
      end
    end
    if (pop_i)  vld_d[rd_ptr_q] = 1'b0;
    if (push_i) vld_d[wr_ptr_q] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop_i && !push_i) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      id_q[wr_ptr_q]   <= push_id_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    idx        = '0;
    lk1_hit_o  = 1'b0;
    lk1_data_o = '0;
    lk2_hit_o  = 1'b0;
    lk2_data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < cnt_q) && vld_q[idx]) begin
        if (id_match(lk1_id_i, id_q[idx])) begin
          lk1_hit_o  = 1'b1;
          lk1_data_o = data_q[idx];
        end
        if (id_match(lk2_id_i, id_q[idx])) begin
          lk2_hit_o  = 1'b1;
          lk2_data_o = data_q[idx];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - merges EX and load-return writes into the single register-file
// write port, with squash of stale loads and forwarding lookups
module regfile_wb_arbiter #(
  parameter int DEPTH    = 4,
  parameter int REG_ID_W = 6,
  parameter int XLEN     = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      ex_valid,
  input  logic [REG_ID_W-1:0]       ex_id,
  input  logic [XLEN-1:0]           ex_data,
  input  logic                      lr_valid,
  output logic                      lr_ready,
  input  logic [REG_ID_W-1:0]       lr_id,
  input  logic [XLEN-1:0]           lr_data,
  output logic                      wr_en,
  output logic [REG_ID_W-1:0]       wr_id,
  output logic [XLEN-1:0]           wr_data,
  input  logic [REG_ID_W-1:0]       lk1_id,
  input  logic [REG_ID_W-1:0]       lk2_id,
  output logic                      lk1_hit,
  output logic [XLEN-1:0]           lk1_data,
  output logic                      lk2_hit,
  output logic [XLEN-1:0]           lk2_data,
  output logic [$clog2(DEPTH):0]    pend_cnt
);
  import regfile_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_req_t          ex_req, lr_req, wr_q, wr_d;
  logic             ex_acc, lr_fire, lr_keep, buf_empty, pop, push, direct;
  logic             head_valid;
  logic [REG_ID_W-1:0] head_id;
  logic [XLEN-1:0]  head_data;
  logic             buf_hit1, buf_hit2, wr_hit1, wr_hit2;
  logic [XLEN-1:0]  buf_data1, buf_data2;

  assign ex_req = '{valid: ex_valid, id: ex_id, data: ex_data};
  assign lr_req = '{valid: lr_valid, id: lr_id, data: lr_data};

  assign buf_empty = (pend_cnt == '0);
  assign lr_ready  = (pend_cnt < CNT_W'(DEPTH));
  assign ex_acc    = ex_req.valid && (ex_req.id != '0);
  assign lr_fire   = lr_req.valid && lr_ready;
  // Same-id EX in the same cycle is the younger instruction, so the load result is dead.
  assign lr_keep   = lr_fire && (lr_req.id != '0) && !(ex_acc && (lr_req.id == ex_req.id));
  assign pop       = !buf_empty && !ex_acc;
  assign push      = lr_keep && (ex_acc || !buf_empty);
  assign direct    = lr_keep && !ex_acc && buf_empty;

  always_comb begin
    wr_d       = wr_q;
    wr_d.valid = 1'b0;
    if (ex_acc) begin
      wr_d = ex_req;
    end else if (pop) begin
      wr_d.valid = head_valid;
      wr_d.id    = head_id;
      wr_d.data  = head_data;
    end else if (direct) begin
      wr_d = lr_req;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wr_q <= '0;
    else         wr_q <= wr_d;
  end

  assign wr_en   = wr_q.valid;
  assign wr_id   = wr_q.id;
  assign wr_data = wr_q.data;

  wb_pend_fifo #(
    .DEPTH (DEPTH)
  ) u_pend (
    .clk          (clk),
    .resetn       (resetn),
    .push_i       (push),
    .push_id_i    (lr_req.id),
    .push_data_i  (lr_req.data),
    .pop_i        (pop),
    .squash_i     (ex_acc),
    .squash_id_i  (ex_req.id),
    .head_valid_o (head_valid),
    .head_id_o    (head_id),
    .head_data_o  (head_data),
    .lk1_id_i     (lk1_id),
    .lk2_id_i     (lk2_id),
    .lk1_hit_o    (buf_hit1),
    .lk1_data_o   (buf_data1),
    .lk2_hit_o    (buf_hit2),
    .lk2_data_o   (buf_data2),
    .cnt_o        (pend_cnt)
  );

  // Buffered entries are always younger than the write stage for the same id.
  assign wr_hit1  = wr_q.valid && id_match(lk1_id, wr_q.id);
  assign wr_hit2  = wr_q.valid && id_match(lk2_id, wr_q.id);
  assign lk1_hit  = buf_hit1 || wr_hit1;
  assign lk2_hit  = buf_hit2 || wr_hit2;
  assign lk1_data = buf_hit1 ? buf_data1 : (wr_hit1 ? wr_q.data : '0);
  assign lk2_data = buf_hit2 ? buf_data2 : (wr_hit2 ? wr_q.data : '0);

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the single-write-port CPU register file (36 entries with IRQ registers, 32 without). It merges the execute-stage write stream (EX, no backpressure, always wins) and the load-return write stream (LR, valid/ready). LR writes that collide with EX are parked in a small pending buffer. The block squashes stale pending loads so that program order is preserved, and it gives the read-register stage combinational forwarding lookups into everything not yet committed.

## Interface
- DEPTH, 4, pending-buffer entries; power of two, ≥2
- REG_ID_W, 6, register id width
- XLEN, 32, data width
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX write request; never stalled
- ex_id  in  REG_ID_W  EX destination register
- ex_data  in  XLEN  EX write data
- lr_valid  in  1  load-return write request
- lr_ready  out  1  LR accept; high when pend_cnt < DEPTH
- lr_id  in  REG_ID_W  LR destination register
- lr_data  in  XLEN  LR write data
- wr_en  out  1  register-file write enable (registered)
- wr_id  out  REG_ID_W  register-file write address
- wr_data  out  XLEN  register-file write data
- lk1_id, lk2_id  in  REG_ID_W  forwarding lookup ids (rs1, rs2)
- lk1_hit, lk2_hit  out  1  an uncommitted value exists for the lookup id
- lk1_data, lk2_data  out  XLEN  forwarded value
- pend_cnt  out  $clog2(DEPTH)+1  occupied buffer entries (valid or squashed)

## Operation
- EX accept: ex_valid && ex_id != 0. LR fire: lr_valid && lr_ready. A fire with lr_id == 0 is consumed and discarded.
- Per-cycle write-slot priority:
  1. EX accept.
  2. Pop the buffer head.
  3. Direct LR (buffer empty, no EX).
- On an LR fire, the LR write is pushed into the buffer if EX is accepted that cycle or the buffer is non-empty. Otherwise it takes the slot directly. FIFO order is preserved.
- Same-cycle EX and LR to the same id: EX is the younger instruction, so the LR is consumed and dropped (not pushed).
- Squash: an EX accept to id X clears the valid bit of every buffer entry with id X in that cycle.
  - A squashed head pops with wr_en=0 next cycle, consuming a slot.
  - Squash and pop in the same cycle are allowed.
- Push while full cannot occur, because lr_ready is low. There is no simultaneous push+pop bypass at full.
- Lookup (combinational, per port): id 0 never hits. Priority:
  1. Youngest valid buffer entry matching the id.
  2. The wr_* register when wr_en=1 and wr_id matches.
  3. Otherwise hit=0 and data=0.
- Buffer entries are always younger than the wr_* contents for the same id, because squash guarantees it.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Fullness is tracked by pend_cnt, not by pointer compare.

## Timing
- Reset values: wr_en=0, wr_id=0, wr_data=0, pend_cnt=0, all buffer valid bits 0, pointers 0.
- lr_ready is combinational from pend_cnt, so it reads 1 after reset.
- Latency from accept to wr_en is 1 cycle for EX and direct LR. A buffered LR takes one cycle after its pop cycle.
- The register file samples wr_* on the next clk edge; the write is visible in the file 2 cycles after accept.
- lr_ready depends only on registered state, not on same-cycle lr_valid or ex_valid.
- pend_cnt updates by +1 on push and −1 on pop, net 0 when both occur.
- Reset asserted mid-operation discards all pending entries; lost loads are the pipeline's refetch responsibility.
- Lookups reflect state before the current edge; the current cycle's ex_* and lr_* are not forwarded.

## Structure
- Shared package regfile_pkg holds:
  - XLEN, REG_ID_W, NUM_REGS (32/36)
  - typedef wb_req_t {valid, id, data}, used for the EX/LR/wr buses
- Sub-module wb_pend_fifo: DEPTH-entry circular buffer with per-entry valid bit, id-CAM squash, and a youngest-first match for both lookup ports.
- The top level holds the slot arbitration, the wr_* register and lr_ready.

## Test plan
- EX id 5 data 0xAAAA_0001 with LR id 6 data 0x1234 in the same cycle:
  - next cycle: wr 5/0xAAAA_0001, pend_cnt=1, lk1_id=6 hits 0x1234
  - following cycle: wr 6/0x1234, pend_cnt=0
- LR to id 7 is buffered behind EX; one cycle later EX writes id 7 = 0x99:
  - the entry is squashed and pops with wr_en=0
  - the register file ends at 0x99
  - lk1_id=7 returns 0x99 from the wr stage
- EX every cycle for 6 cycles while LR streams ids 1..6 (DEPTH=4):
  - lr_ready drops after 4 pushes
  - after EX stops, 4 drains in order, then ids 5 and 6 are accepted
  - no entry is lost or duplicated
- Same-cycle EX and LR both targeting id 3:
  - wr 3 carries the EX data, pend_cnt stays 0
  - the LR handshake completes (lr_ready=1)
- LR to id 0 and EX to id 0: no wr_en, no push, lookups for id 0 never hit.
- resetn pulsed low with 3 entries pending:
  - pend_cnt=0 and wr_en=0 immediately (asynchronous reset)
  - after release, lr_ready=1 and no stale writes occur
